// File: rtl/ad9866_spi_responder.sv
// ad9866_spi_responder
//   SPI target for the 16-bit AD9866 control frame with a 32x8 shadow
//   register file. Stands in for the codec control port and mirrors its
//   register state for local readback.
//
//   Frame (bit 15 first): [15] R/W (1 = read), [14:13] byte count (must be
//   00), [12:8] address, [7:0] data.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   spi_sclk/sdio/sen_n   SPI inputs (sclk idles low, sen_n active low)
//   spi_sdo, spi_sdo_oe   readback data and its enable (reg0[7] = 4-wire)
//   wr_strobe/addr/data   one-cycle pulse with the committed write
//   frame_err             one-cycle pulse on a malformed frame
//   lcl_addr, lcl_data    local readback, 1-cycle registered latency
//
// Build option
//   AD9866_RESPONDER_STATS_EN adds frame_cnt (good frames, wraps) and
//   err_cnt (frame errors, saturates at 8'hFF).
module ad9866_spi_responder #(
  parameter int         SYNC_STAGES = 0,
  parameter logic [7:0] REG0_RESET  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_sdio,
  input  logic       spi_sen_n,
  output logic       spi_sdo,
  output logic       spi_sdo_oe,
  output logic       wr_strobe,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  input  logic [4:0] lcl_addr,
  output logic [7:0] lcl_data
`ifdef AD9866_RESPONDER_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [31:0][7:0] REGS_RESET = {{31{8'h00}}, REG0_RESET};

  logic sclk_s, sdio_s, sen_n_s;

  // Input synchronizers (bypassed when the master shares clk)
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sclk_s  = spi_sclk;
      assign sdio_s  = spi_sdio;
      assign sen_n_s = spi_sen_n;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
      logic [SYNC_STAGES-1:0] sdio_sync_q, sdio_sync_d;
      logic [SYNC_STAGES-1:0] sen_sync_q, sen_sync_d;

      always_comb begin
        sclk_sync_d = SYNC_STAGES'({sclk_sync_q, spi_sclk});
        sdio_sync_d = SYNC_STAGES'({sdio_sync_q, spi_sdio});
        sen_sync_d  = SYNC_STAGES'({sen_sync_q, spi_sen_n});
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sclk_sync_q <= '0;
          sen_sync_q  <= '1;
        end else begin
          sclk_sync_q <= sclk_sync_d;
          sen_sync_q  <= sen_sync_d;
        end
        sdio_sync_q <= sdio_sync_d;
      end

      assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
      assign sdio_s  = sdio_sync_q[SYNC_STAGES-1];
      assign sen_n_s = sen_sync_q[SYNC_STAGES-1];
    end
  endgenerate

  state_t            state_q, state_d;
  logic              sclk_prev_q, sclk_prev_d;
  logic              sen_prev_q, sen_prev_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [15:0]       shift_q, shift_d;
  logic [7:0]        sdo_sr_q, sdo_sr_d;
  logic              sdo_oe_q, sdo_oe_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [4:0]        wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        lcl_data_q, lcl_data_d;
  logic [31:0][7:0]  regs_q, regs_d;

  logic sclk_rise, sen_fall, sen_rise;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sen_fall  = ~sen_n_s & sen_prev_q;
  assign sen_rise  = sen_n_s & ~sen_prev_q;

  always_comb begin
    state_d     = state_q;
    sclk_prev_d = sclk_s;
    sen_prev_d  = sen_n_s;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    sdo_sr_d    = sdo_sr_q;
    sdo_oe_d    = sdo_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    regs_d      = regs_q;
    // Reads the pre-write contents, so a same-cycle write shows up one cycle later
    lcl_data_d  = regs_q[lcl_addr];

    case (state_q)
      IDLE: begin
        if (sen_fall) begin
          state_d = SHIFT;
          cnt_d   = 5'd0;
          shift_d = 16'h0000;
        end
      end
      SHIFT: begin
        // Frame end wins over a coincident sclk rise; that rise is dropped
        if (sen_rise) begin
          state_d  = DONE;
          sdo_oe_d = 1'b0;
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], sdio_s};
          if (cnt_q != 5'd17) begin
            cnt_d = cnt_q + 5'd1;
          end
          // 8th rise completes the header: arm readback for a valid read
          if (cnt_q == 5'd7 && shift_d[7] && shift_d[6:5] == 2'b00) begin
            sdo_sr_d = regs_q[shift_d[4:0]];
            sdo_oe_d = regs_q[0][7];
          end else if (cnt_q >= 5'd8) begin
            sdo_sr_d = {sdo_sr_q[6:0], 1'b0};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (cnt_q == 5'd16 && shift_q[14:13] == 2'b00) begin
          if (!shift_q[15]) begin
            regs_d[shift_q[12:8]] = shift_q[7:0];
            wr_strobe_d           = 1'b1;
            wr_addr_d             = shift_q[12:8];
            wr_data_d             = shift_q[7:0];
          end
        end else if (cnt_q != 5'd0) begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_prev_q <= 1'b0;
      sen_prev_q  <= 1'b1;
      cnt_q       <= 5'd0;
      sdo_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
      lcl_data_q  <= 8'h00;
      regs_q      <= REGS_RESET;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_prev_d;
      sen_prev_q  <= sen_prev_d;
      cnt_q       <= cnt_d;
      sdo_oe_q    <= sdo_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      lcl_data_q  <= lcl_data_d;
      regs_q      <= regs_d;
    end
    shift_q  <= shift_d;
    sdo_sr_q <= sdo_sr_d;
  end

  // sdo is held low whenever it is not carrying read data
  assign spi_sdo    = sdo_sr_q[7] & sdo_oe_q;
  assign spi_sdo_oe = sdo_oe_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_err  = frame_err_q;
  assign lcl_data   = lcl_data_q;

`ifdef AD9866_RESPONDER_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        good_frame;

  assign good_frame = (state_q == DONE) && (cnt_q == 5'd16) && (shift_q[14:13] == 2'b00);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (good_frame) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (frame_err_d && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// Testbench for ad9866_spi_responder: directed frames from the test plan
// followed by randomized frames, checked against a frame-level model of the
// register file and of the expected write/error pulses.
module tb_ad9866_spi_responder;

  localparam int         SYNC = 0;
  localparam logic [7:0] R0   = 8'h00;
  localparam int         HP   = SYNC + 1;  // sclk half period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_sdio = 1'b0;
  logic       spi_sen_n = 1'b1;
  logic [4:0] lcl_addr = 5'd0;
  logic       spi_sdo, spi_sdo_oe, wr_strobe, frame_err;
  logic [4:0] wr_addr;
  logic [7:0] wr_data, lcl_data;
`ifdef AD9866_RESPONDER_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  ad9866_spi_responder #(.SYNC_STAGES(SYNC), .REG0_RESET(R0)) dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_sdio(spi_sdio), .spi_sen_n(spi_sen_n),
    .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .lcl_addr(lcl_addr), .lcl_data(lcl_data)
`ifdef AD9866_RESPONDER_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state
  logic [7:0] mregs [32];
  int         ev_cyc = -1;   // cycle at which the frame outcome must appear
  int         ev_kind = 0;   // 1 write, 2 error, 3 good read
  logic [4:0] ev_addr = 5'd0;
  logic [7:0] ev_data = 8'h00;
  bit         oe_allowed = 1'b0;
  int         lcl_force = -1;
  logic [7:0] exp_lcl = 8'h00;
  int         wr_seen = 0;
  int         err_seen = 0;
  int         good_m = 0;
  int         err_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_sdo_oe", 32'(spi_sdo_oe), 32'd0);
        chk("rst_sdo", 32'(spi_sdo), 32'd0);
        chk("rst_lcl_data", 32'(lcl_data), 32'd0);
        for (int i = 0; i < 32; i++) mregs[i] = 8'h00;
        mregs[0] = R0;
        ev_cyc = -1;
        good_m = 0;
        err_m = 0;
`ifdef AD9866_RESPONDER_STATS_EN
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
      end else begin
        chk("lcl_data", 32'(lcl_data), 32'(exp_lcl));
        if (ev_cyc == cyc) begin
          chk("wr_strobe", 32'(wr_strobe), 32'(ev_kind == 1));
          chk("frame_err", 32'(frame_err), 32'(ev_kind == 2));
          if (ev_kind == 1) begin
            chk("wr_addr", 32'(wr_addr), 32'(ev_addr));
            chk("wr_data", 32'(wr_data), 32'(ev_data));
            mregs[ev_addr] = ev_data;
          end
          if (ev_kind == 1 || ev_kind == 3) good_m++;
          if (ev_kind == 2) err_m++;
          ev_cyc = -1;
        end else begin
          chk("no_wr_strobe", 32'(wr_strobe), 32'd0);
          chk("no_frame_err", 32'(frame_err), 32'd0);
        end
        if (!oe_allowed) chk("sdo_oe_idle", 32'(spi_sdo_oe), 32'd0);
`ifdef AD9866_RESPONDER_STATS_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(16'(good_m)));
        chk("err_cnt", 32'(err_cnt), 32'(err_m > 255 ? 255 : err_m));
`endif
        if (wr_strobe) wr_seen++;
        if (frame_err) err_seen++;
      end
      lcl_addr = (lcl_force >= 0) ? lcl_force[4:0] : 5'($urandom_range(0, 31));
      exp_lcl = mregs[lcl_addr];
    end
  end

  // Drives one frame of n sclk rises. simul raises sclk together with
  // sen_n at the end (that rise must be ignored). rst_at >= 0 aborts the
  // frame with a reset after that many bits.
  task automatic frame(input logic [15:0] w, input int n, input bit simul,
                       input int rst_at, output logic [7:0] rd_bits);
    bit         arm;
    bit         oe_e;
    logic [7:0] rsh;
    logic [15:0] sh;
    int         c0;
    arm  = (n >= 8) && w[15] && (w[14:13] == 2'b00);
    rsh  = mregs[w[12:8]];
    oe_e = mregs[0][7];
    sh   = w;
    rd_bits = 8'h00;
    oe_allowed = arm;
    @(negedge clk);
    spi_sen_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        @(negedge clk);
        rst = 1'b1;
        spi_sen_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        oe_allowed = 1'b0;
        return;
      end
      @(negedge clk);
      spi_sdio = (i < 16) ? sh[15] : 1'($urandom);
      sh = sh << 1;
      spi_sclk = 1'b1;
      if (arm && i >= 8 && i < 16) begin
        chk("rd_sdo_oe", 32'(spi_sdo_oe), 32'(oe_e));
        chk("rd_sdo", 32'(spi_sdo), 32'(oe_e ? rsh[7] : 1'b0));
        rd_bits = {rd_bits[6:0], spi_sdo};
        rsh = rsh << 1;
      end
      repeat (HP - 1) @(negedge clk);
      @(negedge clk);
      spi_sclk = 1'b0;
      repeat (HP - 1) @(negedge clk);
    end
    @(negedge clk);
    spi_sen_n = 1'b1;
    if (simul) spi_sclk = 1'b1;
    c0 = cyc;
    if (n != 0) begin
      if (n == 16 && w[14:13] == 2'b00) ev_kind = w[15] ? 3 : 1;
      else ev_kind = 2;
      ev_addr = w[12:8];
      ev_data = w[7:0];
      ev_cyc  = c0 + 2 + SYNC;
    end
    @(negedge clk);
    spi_sclk = 1'b0;
    repeat (4 + SYNC) @(negedge clk);
    oe_allowed = 1'b0;
  endtask

  task automatic peek(input logic [4:0] a, input string name, input logic [7:0] req);
    lcl_force = int'(a);
    repeat (3) @(negedge clk);
    chk(name, 32'(lcl_data), 32'(req));
    lcl_force = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int ws0, es0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    peek(5'h00, "reg0_reset", R0);

    // Plain write
    ws0 = wr_seen;
    frame(16'h0436, 16, 1'b0, -1, rb);
    peek(5'h04, "wr_0436", 8'h36);
    chk("wr_0436_count", 32'(wr_seen - ws0), 32'd1);

    // 4-wire read of 0x5A
    frame(16'h0B5A, 16, 1'b0, -1, rb);
    frame(16'h0080, 16, 1'b0, -1, rb);
    ws0 = wr_seen;
    es0 = err_seen;
    frame(16'h8B00, 16, 1'b0, -1, rb);
    chk("rd_4wire_bits", 32'(rb), 32'h5A);
    chk("rd_4wire_nowrite", 32'(wr_seen - ws0), 32'd0);

    // 3-wire read: no drive, no error
    frame(16'h0000, 16, 1'b0, -1, rb);
    frame(16'h8B00, 16, 1'b0, -1, rb);
    chk("rd_3wire_bits", 32'(rb), 32'h00);
    chk("rd_3wire_noerr", 32'(err_seen - es0), 32'd0);

    // Truncated, overrun and bad byte count
    es0 = err_seen;
    frame(16'h0477, 10, 1'b0, -1, rb);
    chk("trunc_err", 32'(err_seen - es0), 32'd1);
    frame(16'h0411, 18, 1'b0, -1, rb);
    frame(16'h2455, 16, 1'b0, -1, rb);
    chk("bad_frames_err", 32'(err_seen - es0), 32'd3);
    peek(5'h04, "reg4_kept", 8'h36);
`ifdef AD9866_RESPONDER_STATS_EN
    chk("stats_err_cnt", 32'(err_cnt), 32'd3);
    chk("stats_frame_cnt", 32'(frame_cnt), 32'd6);
`endif

    // sen_n rise coincident with a 17th sclk rise still commits
    frame(16'h0733, 16, 1'b1, -1, rb);
    peek(5'h07, "simul_rise_wr", 8'h33);

    // sen_n pulse with no clocks is silent
    es0 = err_seen;
    frame(16'h0000, 0, 1'b0, -1, rb);
    chk("empty_frame_silent", 32'(err_seen - es0), 32'd0);

    // Reset mid-frame
    ws0 = wr_seen;
    frame(16'h04AA, 16, 1'b0, 12, rb);
    chk("rst_no_write", 32'(wr_seen - ws0), 32'd0);
    peek(5'h04, "rst_reg4", 8'h00);
    peek(5'h07, "rst_reg7", 8'h00);
    frame(16'h1180, 16, 1'b0, -1, rb);
    peek(5'h11, "post_rst_wr", 8'h80);

    // Randomized frames
    for (int k = 0; k < 60; k++) begin
      int          t;
      int          n;
      bit          s;
      logic [15:0] w;
      t = int'($urandom_range(0, 6));
      w = 16'($urandom);
      n = 16;
      s = 1'b0;
      case (t)
        0, 1: w[15:13] = 3'b000;
        2: w[15:13] = 3'b100;
        3: n = int'($urandom_range(1, 15));
        4: n = int'($urandom_range(17, 19));
        5: w[14:13] = 2'(1 + $urandom_range(0, 2));
        default: begin w[15:13] = 3'b000; s = 1'b1; end
      endcase
      frame(w, n, s, -1, rb);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
